// File: rtl/pwm_timer_pkg.sv
// pwm_timer_pkg: register offsets, CTRL bit indices and channel state
// shared by the multi-channel PWM timer and its per-channel engine.
package pwm_timer_pkg;

  localparam logic [1:0] REG_PERIOD = 2'd0;
  localparam logic [1:0] REG_DUTY   = 2'd1;
  localparam logic [1:0] REG_STOP   = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int CTRL_INV  = 0;
  localparam int CTRL_AUTO = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM timer channel (shadow/active regs, counters, FSM).
// Ports: i_clk/i_rstn, i_we/i_reg/i_wdata write, i_start/i_stop, o_pwm/o_timer_end/o_busy.
module pwm_channel
  import pwm_timer_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int CYC_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_we,
  input  logic [1:0]       i_reg,
  input  logic [CNT_W-1:0] i_wdata,
  input  logic             i_start,
  input  logic             i_stop,
  output logic             o_pwm,
  output logic             o_timer_end,
  output logic             o_busy
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] per_sh_q, per_sh_d;
  logic [CNT_W-1:0] duty_sh_q, duty_sh_d;
  logic [CYC_W-1:0] stop_sh_q, stop_sh_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic [CNT_W-1:0] per_act_q, per_act_d;
  logic [CNT_W-1:0] duty_act_q, duty_act_d;
  logic [CYC_W-1:0] stop_act_q, stop_act_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             pwm_q, pwm_d;
  logic             tend_q, tend_d;
  logic             load;
  logic             wrap;
  logic             last;

  always_comb begin
    state_d    = state_q;
    per_sh_d   = per_sh_q;
    duty_sh_d  = duty_sh_q;
    stop_sh_d  = stop_sh_q;
    ctrl_d     = ctrl_q;
    per_act_d  = per_act_q;
    duty_act_d = duty_act_q;
    stop_act_d = stop_act_q;
    cnt_d      = cnt_q;
    cyc_d      = cyc_q;
    tend_d     = 1'b0;
    load       = 1'b0;

    if (i_we) begin
      unique case (1'b1)
        (i_reg == REG_PERIOD): per_sh_d  = i_wdata;
        (i_reg == REG_DUTY):   duty_sh_d = i_wdata;
        (i_reg == REG_STOP):   stop_sh_d = i_wdata[CYC_W-1:0];
        (i_reg == REG_CTRL):   ctrl_d    = i_wdata[1:0];
      endcase
    end

    wrap = (cnt_q == per_act_q - CNT_W'(1));
    last = (stop_act_q != '0) &&
           (cyc_q + CYC_W'(1) == stop_act_q);

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        cyc_d = '0;
        // Loads from *_d so a same-cycle write is picked up.
        if (i_start && per_sh_d != '0) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (wrap) begin
          cnt_d = '0;
          if (last) begin
            tend_d = 1'b1;
            cyc_d  = '0;
            if (ctrl_d[CTRL_AUTO]) begin
              load = 1'b1;
            end else begin
              state_d = DONE;
            end
          end else begin
            load = 1'b1;
            if (cyc_q != '1) begin
              cyc_d = cyc_q + CYC_W'(1);
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
        cyc_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        cyc_d   = '0;
      end
    endcase

    if (i_stop) begin
      state_d = IDLE;
      cnt_d   = '0;
      cyc_d   = '0;
      tend_d  = 1'b0;
    end

    if (load) begin
      per_act_d  = per_sh_d;
      duty_act_d = duty_sh_d;
      stop_act_d = stop_sh_d;
    end

    pwm_d = ((state_d == RUN) && (cnt_d < duty_act_d))
            ^ ctrl_d[CTRL_INV];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q    <= IDLE;
      per_sh_q   <= '0;
      duty_sh_q  <= '0;
      stop_sh_q  <= '0;
      ctrl_q     <= '0;
      per_act_q  <= '0;
      duty_act_q <= '0;
      stop_act_q <= '0;
      cnt_q      <= '0;
      cyc_q      <= '0;
      pwm_q      <= 1'b0;
      tend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      per_sh_q   <= per_sh_d;
      duty_sh_q  <= duty_sh_d;
      stop_sh_q  <= stop_sh_d;
      ctrl_q     <= ctrl_d;
      per_act_q  <= per_act_d;
      duty_act_q <= duty_act_d;
      stop_act_q <= stop_act_d;
      cnt_q      <= cnt_d;
      cyc_q      <= cyc_d;
      pwm_q      <= pwm_d;
      tend_q     <= tend_d;
    end
  end

  assign o_pwm       = pwm_q;
  assign o_timer_end = tend_q;
  assign o_busy      = (state_q == RUN);

endmodule

// File: rtl/pwm_timer_mc.sv
// pwm_timer_mc: N_CH PWM timers behind a write bus; i_addr[1:0] selects the
// register, upper bits the channel; outputs o_pwm/o_timer_end/o_busy per channel.
module pwm_timer_mc
  import pwm_timer_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int N_CH   = 4,
  parameter int CYC_W  = 8,
  parameter int ADDR_W = $clog2(N_CH) + 2
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [CNT_W-1:0]  i_wdata,
  input  logic [N_CH-1:0]   i_start,
  input  logic [N_CH-1:0]   i_stop,
  output logic [N_CH-1:0]   o_pwm,
  output logic [N_CH-1:0]   o_timer_end,
  output logic [N_CH-1:0]   o_busy
);

  localparam int CH_W = (ADDR_W > 2) ? ADDR_W - 2 : 1;

  logic [CH_W-1:0] ch_idx;
  logic [N_CH-1:0] we_vec;

  if (ADDR_W > 2) begin : g_idx
    assign ch_idx = i_addr[ADDR_W-1:2];
  end else begin : g_idx0
    assign ch_idx = '0;
  end

  // Indices past N_CH match no channel, so those writes drop.
  always_comb begin
    we_vec = '0;
    for (int i = 0; i < N_CH; i++) begin
      we_vec[i] = i_we && (int'(ch_idx) == i);
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pwm_channel #(
      .CNT_W(CNT_W),
      .CYC_W(CYC_W)
    ) u_ch (
      .i_clk      (i_clk),
      .i_rstn     (i_rstn),
      .i_we       (we_vec[g]),
      .i_reg      (i_addr[1:0]),
      .i_wdata    (i_wdata),
      .i_start    (i_start[g]),
      .i_stop     (i_stop[g]),
      .o_pwm      (o_pwm[g]),
      .o_timer_end(o_timer_end[g]),
      .o_busy     (o_busy[g])
    );
  end

endmodule

// File: tb/tb_pwm_timer_mc.sv
// tb_pwm_timer_mc: table/sequence checks of pwm_timer_mc plus a random
// run compared every cycle with a behavioural model.
module tb_pwm_timer_mc;

  localparam int CNT_W  = 16;
  localparam int N_CH   = 4;
  localparam int CYC_W  = 8;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rstn;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  wdata;
  logic [N_CH-1:0]   start;
  logic [N_CH-1:0]   stop;
  logic [N_CH-1:0]   pwm;
  logic [N_CH-1:0]   tend;
  logic [N_CH-1:0]   busy;

  always #5 clk = ~clk;

  pwm_timer_mc #(
    .CNT_W (CNT_W),
    .N_CH  (N_CH),
    .CYC_W (CYC_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_we       (we),
    .i_addr     (addr),
    .i_wdata    (wdata),
    .i_start    (start),
    .i_stop     (stop),
    .o_pwm      (pwm),
    .o_timer_end(tend),
    .o_busy     (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state, plain integers.
  int s_per[N_CH], s_duty[N_CH], s_stop[N_CH];
  int a_per[N_CH], a_duty[N_CH], a_stop[N_CH];
  int pos[N_CH], ncyc[N_CH];
  bit inv[N_CH], aut[N_CH], run[N_CH], fin[N_CH];
  logic [N_CH-1:0] e_pwm, e_end, e_busy;

  typedef struct {
    int   t;
    logic pwm;
    logic tend;
    logic busy;
  } vec_t;

  vec_t tab[10];

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic reload(int c);
    a_per[c]  = s_per[c];
    a_duty[c] = s_duty[c];
    a_stop[c] = s_stop[c];
  endtask

  task automatic model_edge();
    bit wr;
    bit pulse;
    int nxt;
    if (!rstn) begin
      for (int c = 0; c < N_CH; c++) begin
        s_per[c] = 0; s_duty[c] = 0; s_stop[c] = 0;
        a_per[c] = 0; a_duty[c] = 0; a_stop[c] = 0;
        pos[c] = 0; ncyc[c] = 0;
        inv[c] = 0; aut[c] = 0; run[c] = 0; fin[c] = 0;
      end
      e_pwm = '0; e_end = '0; e_busy = '0;
      return;
    end
    for (int c = 0; c < N_CH; c++) begin
      wr = we && (int'(addr[ADDR_W-1:2]) == c);
      if (wr) begin
        case (addr[1:0])
          2'd0: s_per[c] = int'(wdata);
          2'd1: s_duty[c] = int'(wdata);
          2'd2: s_stop[c] = int'(wdata[CYC_W-1:0]);
          default: begin
            inv[c] = wdata[0];
            aut[c] = wdata[1];
          end
        endcase
      end
      pulse = 0;
      if (stop[c]) begin
        run[c] = 0; fin[c] = 0; pos[c] = 0; ncyc[c] = 0;
      end else if (run[c]) begin
        if (pos[c] + 1 == a_per[c]) begin
          pos[c] = 0;
          nxt = ncyc[c] + 1;
          if (a_stop[c] != 0 && nxt == a_stop[c]) begin
            pulse = 1;
            ncyc[c] = 0;
            if (aut[c]) reload(c);
            else begin
              run[c] = 0;
              fin[c] = 1;
            end
          end else begin
            ncyc[c] = (nxt > 255) ? 255 : nxt;
            reload(c);
          end
        end else begin
          pos[c]++;
        end
      end else if (fin[c]) begin
        fin[c] = 0;
      end else if (start[c] && s_per[c] != 0) begin
        run[c] = 1; pos[c] = 0; ncyc[c] = 0;
        reload(c);
      end
      e_pwm[c]  = (run[c] && pos[c] < a_duty[c]) ^ inv[c];
      e_end[c]  = pulse;
      e_busy[c] = run[c];
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("model", {20'd0, pwm, tend, busy}, {20'd0, e_pwm, e_end, e_busy});
    we    = 1'b0;
    start = '0;
    stop  = '0;
  endtask

  task automatic wr(int ch, int r, int d);
    we    = 1'b1;
    addr  = ADDR_W'((ch << 2) | r);
    wdata = CNT_W'(d);
    tick();
  endtask

  initial begin
    tab[0] = '{1,  1'b1, 1'b0, 1'b1};
    tab[1] = '{3,  1'b1, 1'b0, 1'b1};
    tab[2] = '{4,  1'b0, 1'b0, 1'b1};
    tab[3] = '{10, 1'b0, 1'b0, 1'b1};
    tab[4] = '{11, 1'b1, 1'b0, 1'b1};
    tab[5] = '{13, 1'b1, 1'b0, 1'b1};
    tab[6] = '{14, 1'b0, 1'b0, 1'b1};
    tab[7] = '{20, 1'b0, 1'b0, 1'b1};
    tab[8] = '{21, 1'b0, 1'b1, 1'b0};
    tab[9] = '{22, 1'b0, 1'b0, 1'b0};

    rstn = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    start = '0; stop = '0;
    tick();
    tick();
    check("reset", {20'd0, pwm, tend, busy}, 32'd0);
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle", {20'd0, pwm, tend, busy}, 32'd0);
    end
    start[0] = 1'b1;
    tick();
    check("start_per0", 32'(busy[0]), 32'd0);

    // ch0: PERIOD 10, DUTY 3, STOP 2
    wr(0, 0, 10); wr(0, 1, 3); wr(0, 2, 2);
    start[0] = 1'b1;
    begin
      int ends = 0;
      for (int t = 1; t <= 22; t++) begin
        tick();
        if (tend[0]) ends++;
        for (int i = 0; i < 10; i++) begin
          if (tab[i].t == t) begin
            check("ch0_tab", {29'd0, pwm[0], tend[0], busy[0]},
                  {29'd0, tab[i].pwm, tab[i].tend, tab[i].busy});
          end
        end
      end
      check("ch0_ends", 32'(ends), 32'd1);
    end

    // ch1: PERIOD 8, DUTY 8, INV; DUTY->0 mid-period
    wr(1, 0, 8); wr(1, 1, 8); wr(1, 3, 1);
    start[1] = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      if (t == 12) begin
        we = 1'b1; addr = ADDR_W'((1 << 2) | 1); wdata = '0;
      end
      tick();
      check("ch1_pwm", 32'(pwm[1]), (t >= 17) ? 32'd1 : 32'd0);
    end
    stop[1] = 1'b1;
    tick();
    check("ch1_stop", {30'd0, pwm[1], busy[1]}, 32'd2);

    // ch0 AUTO: PERIOD 4, DUTY 2, STOP 3
    wr(0, 0, 4); wr(0, 1, 2); wr(0, 2, 3); wr(0, 3, 2);
    start[0] = 1'b1;
    for (int t = 1; t <= 48; t++) begin
      tick();
      check("auto_wave", {29'd0, pwm[0], tend[0], busy[0]},
            {29'd0, ((t - 1) % 4) < 2,
             (t == 13 || t == 25 || t == 37), 1'b1});
    end
    stop[0] = 1'b1;
    tick();
    check("auto_stop", {30'd0, tend[0], busy[0]}, 32'd0);

    // ch2/ch3 independent
    wr(2, 0, 5); wr(2, 1, 2); wr(3, 0, 7); wr(3, 1, 3);
    start = 4'b1100;
    for (int t = 1; t <= 20; t++) begin
      tick();
      check("ch23_wave", {30'd0, pwm[3], pwm[2]},
            {30'd0, ((t - 1) % 7) < 3, ((t - 1) % 5) < 2});
    end
    stop = 4'b1100;
    tick();
    start[2] = 1'b1;
    stop[2]  = 1'b1;
    tick();
    check("ch2_startstop", 32'(busy[2]), 32'd0);
    tick();
    check("ch2_idle", 32'(busy[2]), 32'd0);

    // reset mid-run
    start = '1;
    tick();
    check("all_busy", 32'(busy), 32'hF);
    for (int i = 0; i < 5; i++) tick();
    rstn = 1'b0;
    tick();
    check("mid_reset", {20'd0, pwm, tend, busy}, 32'd0);
    rstn = 1'b1;
    start = '1;
    tick();
    check("post_reset", {20'd0, pwm, busy}, 32'd0);

    // random traffic vs model
    for (int i = 0; i < 3000; i++) begin
      rstn = ($urandom_range(0, 699) != 0);
      if ($urandom_range(0, 9) < 4) begin
        int r;
        r     = $urandom_range(0, 3);
        we    = 1'b1;
        addr  = ADDR_W'(($urandom_range(0, 3) << 2) | r);
        case (r)
          0: wdata = CNT_W'($urandom_range(1, 12));
          1: wdata = CNT_W'($urandom_range(0, 14));
          2: wdata = CNT_W'($urandom_range(0, 4));
          default: wdata = CNT_W'($urandom_range(0, 3));
        endcase
      end
      for (int c = 0; c < N_CH; c++) begin
        start[c] = ($urandom_range(0, 9) == 0);
        stop[c]  = ($urandom_range(0, 39) == 0);
      end
      tick();
    end
    rstn = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
